// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage. Holds the PC and drives the instruction
//             memory address. Decodes 16/32-bit instruction length from the
//             first halfword and loads the IF/ID register. Supports a
//             boot-vector load, stall, branch redirect/flush and halt.
//  Ports    : clk, reset_b       - clock, synchronous active-low reset
//             imem_addr          - word address to instruction memory
//             imem_data          - {word[addr+1], word[addr]}, combinational
//             stall              - hold PC and IF/ID
//             branch_taken/target- redirect request and new PC
//             ifid_inst/pc/is_long/valid - IF/ID pipeline register
//             halted             - HLT fetched, fetching stopped
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = '0,
  parameter int                LONG_BIT       = 15,
  parameter logic [4:0]        HLT_OPC        = 5'b00001
) (
  input  logic              clk,
  input  logic              reset_b,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [31:0]       ifid_inst,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic              ifid_is_long,
  output logic              ifid_valid,
  output logic              halted
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ifid_inst;
  logic [ADDR_W-1:0] r_ifid_pc;
  logic              r_ifid_is_long;
  logic              r_ifid_valid;

  logic [15:0]       w_h0;
  logic              w_long;
  logic              w_is_hlt;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_boot_pc;
  logic              w_boot_load;
  logic              w_redirect;
  logic              w_fetch;
  logic              w_halt_hold;

  // Length/opcode decode of the word currently presented by memory.
  assign w_h0      = imem_data[15:0];
  assign w_long    = w_h0[LONG_BIT];
  assign w_is_hlt  = (w_h0[15:11] == HLT_OPC);
  assign w_next_pc = r_pc + (w_long ? ADDR_W'(2) : ADDR_W'(1));
  // The boot vector is the full 32-bit fetch word.
  assign w_boot_pc = ADDR_W'(imem_data);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: branch outranks stall, and only an unstalled,
  // unredirected fetch of HLT enters HALT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (!branch_taken && !stall && w_is_hlt) begin
          w_state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        if (branch_taken) begin
          w_state_nxt = S_RUN;
        end
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Output / control decode from state
  always_comb begin
    imem_addr   = r_pc;
    halted      = 1'b0;
    w_boot_load = 1'b0;
    w_redirect  = 1'b0;
    w_fetch     = 1'b0;
    w_halt_hold = 1'b0;
    case (r_state)
      S_BOOT: begin
        imem_addr   = RESET_VEC_ADDR;
        w_boot_load = 1'b1;
      end
      S_RUN: begin
        w_redirect = branch_taken;
        w_fetch    = !branch_taken && !stall;
      end
      S_HALT: begin
        halted      = 1'b1;
        w_redirect  = branch_taken;
        w_halt_hold = !branch_taken;
      end
      default: ;
    endcase
  end

  // PC and IF/ID register
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      r_pc           <= '0;
      r_ifid_inst    <= '0;
      r_ifid_pc      <= '0;
      r_ifid_is_long <= 1'b0;
      r_ifid_valid   <= 1'b0;
    end else if (w_boot_load) begin
      r_pc <= w_boot_pc;
    end else if (w_redirect) begin
      // Flush the wrong-path instruction; the target is fetched next cycle.
      r_pc         <= branch_target;
      r_ifid_valid <= 1'b0;
    end else if (w_fetch) begin
      r_ifid_inst    <= w_long ? imem_data : {16'h0000, w_h0};
      r_ifid_pc      <= r_pc;
      r_ifid_is_long <= w_long;
      r_ifid_valid   <= 1'b1;
      r_pc           <= w_next_pc;
    end else if (w_halt_hold) begin
      r_ifid_valid <= 1'b0;
    end
  end

  assign ifid_inst    = r_ifid_inst;
  assign ifid_pc      = r_ifid_pc;
  assign ifid_is_long = r_ifid_is_long;
  assign ifid_valid   = r_ifid_valid;

endmodule
`default_nettype wire
